// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryption round controller: one round per clock over a single state register.
// Build option: define AES_ZEROIZE_EN to clear the state register on the output handshake.
module aes_enc_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    output logic [3:0]   rk_idx,
    input  logic [0:127] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e       state_q;
    logic [0:127] st_q;
    logic [3:0]   rnd_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [0:127] sr_d;
    logic [0:127] st_round_d;
    logic [0:127] st_final_d;

    // NOTE: locals inside functions are plain variables, so blocking '=' is correct here.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = x;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [0:127] sub_bytes(input logic [0:127] s);
        logic [0:127] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
        return r;
    endfunction

    // Byte 4*c+row sits at (row, column c); row r rotates left by r columns.
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] r;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[8*(4*c+row) +: 8] = s[8*(4*((c+row)%4)+row) +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:127] mix_col(input logic [0:127] s);
        logic [0:127] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            r[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    always_comb begin
        sr_d       = shift_rows(sub_bytes(st_q));
        st_final_d = sr_d ^ rk;
        st_round_d = mix_col(sr_d) ^ rk;
    end

    // NOTE: all state below updates with non-blocking '<=' so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            st_q        <= '0;
            rnd_q       <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (rnd_q > 4'd10) begin
            state_q     <= IDLE;
            rnd_q       <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        st_q       <= in_data ^ rk;
                        rnd_q      <= 4'd1;
                        state_q    <= ROUND;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ROUND: begin
                    st_q  <= st_round_d;
                    rnd_q <= rnd_q + 4'd1;
                    if (rnd_q == 4'd9) state_q <= FINAL;
                end
                FINAL: begin
                    st_q        <= st_final_d;
                    rnd_q       <= 4'd0;
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
`ifdef AES_ZEROIZE_EN
                        st_q        <= '0;
`else
                        st_q        <= st_q;
`endif
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rnd_q       <= 4'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign rk_idx    = rnd_q;
    assign out_data  = st_q;

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Self-checking bench for aes_enc_ctrl: FIPS-197 vectors, backpressure, mid-block reset and random
// blocks checked against a byte-level AES model with its own key schedule (honours AES_ZEROIZE_EN).
module tb_aes_enc_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [0:127] in_data = '0;
    logic [3:0]   rk_idx;
    logic [0:127] rk;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [0:127] out_data;
    logic         busy;

    always #5 clk = ~clk;

    aes_enc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic [7:0]   sbox_tbl [256];
    logic [0:127] rkeys    [11];
    time          t_accept;
    int           n_checks = 0;
    int           n_pass   = 0;

    // Key-schedule model: returns the requested round key combinationally.
    assign rk = (rk_idx <= 4'd10) ? rkeys[rk_idx] : '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        while (y != 8'h00) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Table built by walking generator 3 and its inverse together.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01; q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_tbl[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_tbl[0] = 8'h63;
    endtask

    task automatic set_key(input logic [0:127] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [0:127] model_enc(input logic [0:127] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   acc;
        logic [7:0]   coef [4];
        logic [0:127] res;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ rkeys[0][8*i +: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_tbl[s[i]];
            for (int i = 0; i < 16; i++) s[i] = t[(i + 4*(i%4)) % 16];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int row = 0; row < 4; row++) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - row + 4) % 4], s[4*c+k]);
                        t[4*c+row] = acc;
                    end
                end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkeys[r][8*i +: 8];
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
        return res;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctrl"}, {in_ready, out_valid, busy, rk_idx}, 7'b100_0000);
        check({tag, "_data"}, out_data, 128'h0);
    endtask

    // Called on a negedge with the DUT idle or finishing; returns on the negedge after the handshake.
    task automatic run_block(input logic [0:127] pt, input logic [0:127] exp, input int stall,
                             input logic hold_valid, input logic [0:127] nxt, input string tag);
        int n;
        int waited;
        in_valid = 1'b1;
        in_data  = pt;
        waited   = 0;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check({tag, "_accept_timeout"}, 1'b0, 1'b1);
            in_valid = 1'b0;
            return;
        end
        check({tag, "_rk_idle"}, rk_idx, 4'd0);
        t_accept = $time;
        @(negedge clk);
        n = 1;
        in_valid = hold_valid;
        in_data  = nxt;
        check({tag, "_ready_busy"}, {in_ready, busy}, 2'b01);
        while (!out_valid && n < 20) begin
            if (n <= 10) check($sformatf("%s_rk_idx%0d", tag, n), rk_idx, n[3:0]);
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 11);
        check({tag, "_out_valid"}, out_valid, 1'b1);
        check({tag, "_rk_done"}, rk_idx, 4'd0);
        check({tag, "_ct"}, out_data, exp);
        out_ready = (stall == 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, "_bp_ctrl"}, {out_valid, in_ready, busy}, 3'b101);
            check({tag, "_bp_ct"}, out_data, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_post_hs_ctrl"}, {in_ready, out_valid, busy, rk_idx}, 7'b100_0000);
`ifdef AES_ZEROIZE_EN
        check({tag, "_zeroize"}, out_data, 128'h0);
`else
        check({tag, "_hold_ct"}, out_data, exp);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        time          t_first;
        int           waited;
        logic [0:127] key, pt;
        build_sbox();

        // Reset held for three cycles, then idle with no traffic.
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle_outputs("reset");
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_idle_outputs("idle");
        end

        // FIPS-197 Appendix B.
        set_key(KEY_B);
        out_ready = 1'b1;
        run_block(PT_B, CT_B, 0, 1'b0, '0, "fips_b");
        @(negedge clk);

        // Appendix C.1 followed back-to-back by Appendix B with in_valid held high.
        set_key(KEY_C);
        run_block(PT_C, CT_C, 0, 1'b1, PT_B, "c1_b2b");
        t_first = t_accept;
        set_key(KEY_B);
        run_block(PT_B, CT_B, 0, 1'b0, '0, "b_b2b");
        check("b2b_spacing", (t_accept - t_first) / 10, 12);
        @(negedge clk);

        // Backpressure with a competing block offered throughout.
        out_ready = 1'b0;
        run_block(PT_B, CT_B, 20, 1'b1, PT_C, "bp");
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("bp_single_hs", {out_valid, busy, in_ready}, 3'b001);
        end

        // Reset pulse while round key 5 is requested.
        set_key(KEY_C);
        in_valid = 1'b1;
        in_data  = PT_C;
        waited   = 0;
        while (rk_idx != 4'd5 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("mid_rst_reach_rk5", rk_idx, 4'd5);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_idle_outputs("mid_rst_async");
        @(negedge clk);
        check_idle_outputs("mid_rst_hold");
        rst_n = 1'b1;
        run_block(PT_C, CT_C, 0, 1'b0, '0, "post_rst");
        in_valid = 1'b0;

        // Random keys, plaintexts, stalls and idle gaps.
        for (int b = 0; b < 8; b++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            set_key(key);
            out_ready = $urandom_range(0, 1) == 1;
            run_block(pt, model_enc(pt), $urandom_range(0, 3), 1'b0, '0, $sformatf("rand%0d", b));
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_enc_ctrl.md
# aes_enc_ctrl

Iterative AES-128 encryption round controller. Sequences the combinational round datapath (sub_bytes → shift_rows → mix_col → AddRoundKey) over a single 128-bit state register, one round per clock. It fetches round keys from the key-schedule block through an index/data port and hands ciphertext out on a valid/ready interface. It sits between the host block buffer and the key-schedule RAM/ROM.

## Interface
- No parameters. Key size is fixed at 128 bits, with 10 rounds.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  controller can accept a block (high only in IDLE).
- in_data  in  [0:127]  plaintext; byte 0 = bits [0:7]; column-major byte order matching mix_col.
- rk_idx  out  [3:0]  round-key index requested, 0..10.
- rk  in  [0:127]  round key for rk_idx; the key schedule returns it combinationally in the same cycle.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  downstream accepts ciphertext.
- out_data  out  [0:127]  ciphertext; driven directly from the state register.
- busy  out  1  high in ROUND, FINAL and DONE.

## Operation
- Registers:
  - st (128 bits)
  - rnd (4 bits)
  - fsm: IDLE, ROUND, FINAL, DONE
- rk_idx = rnd at all times.
- IDLE:
  - in_ready=1, rnd=0.
  - On in_valid&in_ready: st ← in_data ^ rk (key 0), rnd ← 1, go to ROUND.
- ROUND:
  - st ← mix_col(shift_rows(sub_bytes(st))) ^ rk, rnd ← rnd+1.
  - When rnd==9, this update completes round 9: set rnd ← 10 and go to FINAL.
- FINAL:
  - st ← shift_rows(sub_bytes(st)) ^ rk. MixColumns is bypassed in this round.
  - rnd ← 0, go to DONE.
- DONE:
  - out_valid=1.
  - st is frozen while out_ready=0.
  - On out_ready: go to IDLE.
- in_valid and in_data are ignored outside IDLE. out_ready is ignored outside DONE.
- A new block is accepted only from IDLE. There is no accept in DONE, even if out_ready and in_valid are both high in the same cycle.
- rnd never exceeds 10. Values 11–15 are unreachable; if ever decoded, the FSM goes to IDLE.
- All XORs are 128-bit bitwise. There is no carry arithmetic. rnd increments only in ROUND and cannot wrap.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - fsm=IDLE, st=0, rnd=0.
  - in_ready=1, out_valid=0, busy=0, rk_idx=0, out_data=0.
- Reset mid-operation aborts the block. out_valid is never asserted for it, and operation resumes in IDLE after release.
- The accept edge is E0. Rounds 1..9 update on E1..E9, and the final round updates on E10.
- out_valid rises after E10: 11 cycles of latency from accept to out_valid.
- The output handshake edge returns fsm to IDLE. The next accept is possible one edge later.
- Minimum spacing between consecutive accepts is 12 cycles (11 busy cycles plus 1 IDLE cycle) when out_ready is held high.
- out_data and out_valid stay stable under backpressure until the handshake.
- in_ready falls on the edge after acceptance. busy is the registered complement of the IDLE state.
- rk must be valid in the same cycle as rk_idx. Because rk_idx is registered, the key path gets a full cycle.

## Configuration
- AES_ZEROIZE_EN defined:
  - On the DONE→IDLE handshake edge, st ← 0.
  - out_data reads 0 whenever fsm ≠ DONE except during ROUND/FINAL, when it shows intermediate state.
- AES_ZEROIZE_EN undefined:
  - st retains the ciphertext after the handshake.
  - out_data keeps showing it in IDLE until the next accept.
- The FSM and latency are identical in both builds.

## Test plan
- Reset then idle:
  - Stimulus: rst_n low for 3 cycles, then released, no in_valid.
  - Required: in_ready=1, out_valid=0, busy=0, rk_idx=0, out_data=0 throughout.
- FIPS-197 App. B:
  - Stimulus: pt 3243f6a8885a308d313198a2e0370734, bench key-schedule model for key 2b7e151628aed2a6abf7158809cf4f3c, out_ready=1.
  - Required: out_data=3925841d02dc09fbdc118597196a0b32 exactly 11 cycles after accept.
  - Required: rk_idx sequence 0,1,…,10,0.
- FIPS-197 App. C.1, back-to-back:
  - Stimulus: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, then App. B pt with in_valid held high.
  - Required: 69c4e0d86a7b0430d8cdb78070b4c55a, then 3925841d…0b32; the two accepts are 12 cycles apart.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles after out_valid, with in_valid=1 driving a different block.
  - Required: out_data stays 3925841d…0b32, in_ready=0, and the second block is not accepted.
  - Required: after out_ready=1, exactly one handshake occurs.
- Mid-block reset:
  - Stimulus: rst_n pulsed low while rk_idx=5.
  - Required: immediate reset values.
  - Required: the next block, C.1, yields correct ciphertext with correct latency.
- Zeroize:
  - With AES_ZEROIZE_EN: out_data=0 the cycle after the handshake.
  - Without AES_ZEROIZE_EN: out_data holds the ciphertext in IDLE.
